multiplier_4x4: RTL and testbench

Registered 4×4 unsigned approximate multiplier for error-tolerant datapaths. Low-order partial-product columns are OR-combined instead of added, which removes carry logic in the least-significant part. High-order columns are summed exactly. The result is an 8-bit product one cycle after the operands are presented; the block sits between operand registers and downstream accumulate/compare logic.

---
 rtl/multiplier_4x4_pkg.sv | 15 +
 rtl/multiplier_4x4_pp_gen.sv | 19 +
 rtl/multiplier_4x4.sv | 72 +++++++
 tb/tb_multiplier_4x4.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/multiplier_4x4_pkg.sv
// Shared widths, operand/product types and column layout for multiplier_4x4.
package multiplier_4x4_pkg;

    localparam int unsigned OP_W                = 4;
    localparam int unsigned PROD_W              = 8;
    localparam int unsigned APPROX_COLS_DEFAULT = 3;
    localparam int unsigned NUM_COLS            = 2 * OP_W - 1;

    typedef logic [OP_W-1:0]   operand_t;
    typedef logic [PROD_W-1:0] product_t;

    // col_pp_t[k][i] holds A[i] & B[k-i]; slots with no valid (i, k-i) pair stay 0.
    typedef logic [NUM_COLS-1:0][OP_W-1:0] col_pp_t;

endpackage

// File: rtl/multiplier_4x4_pp_gen.sv
// AND partial-product generator; groups the 16 products by column weight.
module multiplier_4x4_pp_gen
    import multiplier_4x4_pkg::*;
(
    input  operand_t a,
    input  operand_t b,
    output col_pp_t  pp
);

    always_comb begin
        pp = '0;
        for (int unsigned i = 0; i < OP_W; i++) begin
            for (int unsigned j = 0; j < OP_W; j++) begin
                pp[i + j][i] = a[i] & b[j];
            end
        end
    end

endmodule

// File: rtl/multiplier_4x4.sv
// Registered 4x4 unsigned approximate multiplier (OR-combined low columns).
// Define MULTIPLIER_4X4_EXACT_EN to build the exact A*B baseline instead.
module multiplier_4x4
    import multiplier_4x4_pkg::*;
#(
    parameter int unsigned APPROX_COLS = APPROX_COLS_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [OP_W-1:0]       A,
    input  logic [OP_W-1:0]       B,
    output logic [PROD_W-1:0]     P,
    output logic                  out_valid
);

`ifdef MULTIPLIER_4X4_EXACT_EN
    // Summing every column exactly reproduces A*B.
    localparam int unsigned EFF_COLS = 0;
`else
    localparam int unsigned EFF_COLS = APPROX_COLS;
`endif

    col_pp_t  pp;
    product_t low_part;
    product_t high_part;
    product_t prod;
    product_t p_d, p_q;
    logic     out_valid_d, out_valid_q;

    multiplier_4x4_pp_gen u_pp_gen (
        .a  (A),
        .b  (B),
        .pp (pp)
    );

    // Low columns never generate carries, so they simply fill the bits the high sum leaves at 0.
    always_comb begin
        low_part  = '0;
        high_part = '0;
        for (int unsigned k = 0; k < NUM_COLS; k++) begin
            if (k < EFF_COLS) begin
                low_part[k] = |pp[k];
            end else begin
                high_part = high_part + (product_t'($countones(pp[k])) << k);
            end
        end
        prod = high_part + low_part;
    end

    always_comb begin
        p_d         = p_q;
        out_valid_d = in_valid;
        if (in_valid) begin
            p_d = prod;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_q         <= '0;
            out_valid_q <= 1'b0;
        end else begin
            p_q         <= p_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign P         = p_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_multiplier_4x4.sv
// Directed self-checking bench for multiplier_4x4 (default and APPROX_COLS=0 instances).
module tb_multiplier_4x4;

    logic       clk = 1'b0;
    bit         clk_en = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] A, B;
    logic [7:0] p3, p0;
    logic       ov3, ov0;

    int tests_run    = 0;
    int tests_failed = 0;

    multiplier_4x4 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .A         (A),
        .B         (B),
        .P         (p3),
        .out_valid (ov3)
    );

    multiplier_4x4 #(.APPROX_COLS(0)) dut_exact (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .A         (A),
        .B         (B),
        .P         (p0),
        .out_valid (ov0)
    );

    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    // Column model: columns below cols are OR-combined, the rest are counted exactly.
    function automatic logic [7:0] model(input logic [3:0] a, input logic [3:0] b,
                                         input int unsigned cols);
        int unsigned sum = 0;
        for (int k = 0; k < 7; k++) begin
            int unsigned cnt = 0;
            for (int i = 0; i < 4; i++) begin
                int j = k - i;
                if (j >= 0 && j < 4 && a[i] && b[j]) cnt++;
            end
            if (k < int'(cols)) sum += ((cnt != 0) ? 1 : 0) << k;
            else                sum += cnt << k;
        end
        return sum[7:0];
    endfunction

    function automatic logic [7:0] expected_default(input logic [3:0] a, input logic [3:0] b);
`ifdef MULTIPLIER_4X4_EXACT_EN
        return 8'(a) * 8'(b);
`else
        return model(a, b, 3);
`endif
    endfunction

    task automatic test_reset();
        rst_n = 1'b1; in_valid = 1'b0; A = 4'd0; B = 4'd0;
        #3 rst_n = 1'b0;
        #2;
        tests_run++;
        if (p3 !== 8'd0) begin
            tests_failed++; $display("FAIL reset_p: P=%0d expected 0", p3);
        end
        tests_run++;
        if (ov3 !== 1'b0) begin
            tests_failed++; $display("FAIL reset_valid: out_valid=%b expected 0", ov3);
        end
        clk_en = 1'b1;
        @(negedge clk) rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk) #1;
            tests_run++;
            if (p3 !== 8'd0 || ov3 !== 1'b0) begin
                tests_failed++;
                $display("FAIL post_reset_idle: P=%0d out_valid=%b expected 0/0", p3, ov3);
            end
        end
    endtask

    task automatic apply_and_check(input string name, input logic [3:0] a,
                                   input logic [3:0] b, input logic [7:0] exp_p);
        @(negedge clk);
        A = a; B = b; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        tests_run++;
        if (p3 !== exp_p || ov3 !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s: %0dx%0d P=%0d out_valid=%b expected P=%0d out_valid=1",
                     name, a, b, p3, ov3, exp_p);
        end
    endtask

    task automatic test_approx_pairs();
`ifdef MULTIPLIER_4X4_EXACT_EN
        apply_and_check("pair_3x3",   4'd3,  4'd3,  8'd9);
        apply_and_check("pair_5x5",   4'd5,  4'd5,  8'd25);
        apply_and_check("pair_7x7",   4'd7,  4'd7,  8'd49);
        apply_and_check("pair_15x15", 4'd15, 4'd15, 8'd225);
`else
        apply_and_check("pair_3x3",   4'd3,  4'd3,  8'd7);
        apply_and_check("pair_5x5",   4'd5,  4'd5,  8'd21);
        apply_and_check("pair_7x7",   4'd7,  4'd7,  8'd39);
        apply_and_check("pair_15x15", 4'd15, 4'd15, 8'd215);
`endif
    endtask

    task automatic test_exact_cases();
        apply_and_check("exact_1x13", 4'd1, 4'd13, 8'd13);
        apply_and_check("exact_8x15", 4'd8, 4'd15, 8'd120);
        apply_and_check("exact_0x9",  4'd0, 4'd9,  8'd0);
        apply_and_check("exact_4x6",  4'd4, 4'd6,  8'd24);
    endtask

    task automatic test_back_to_back_sweep();
        real err_sum = 0.0;
        int  nz = 0;
        for (int n = 0; n < 256; n++) begin
            logic [3:0] a, b;
            logic [7:0] ex;
            logic [7:0] e3;
            a = 4'(n >> 4); b = 4'(n);
            ex = 8'(a) * 8'(b);
            e3 = expected_default(a, b);
            @(negedge clk);
            A = a; B = b; in_valid = 1'b1;
            @(posedge clk) #1;
            tests_run++;
            if (p3 !== e3 || ov3 !== 1'b1) begin
                tests_failed++;
                $display("FAIL sweep_model: %0dx%0d P=%0d out_valid=%b expected %0d/1",
                         a, b, p3, ov3, e3);
            end
            tests_run++;
            if (p3 > ex) begin
                tests_failed++;
                $display("FAIL sweep_bound: %0dx%0d P=%0d exceeds exact %0d", a, b, p3, ex);
            end
            tests_run++;
            if (p0 !== ex || ov0 !== 1'b1) begin
                tests_failed++;
                $display("FAIL sweep_cols0: %0dx%0d P=%0d out_valid=%b expected %0d/1",
                         a, b, p0, ov0, ex);
            end
            if (ex != 0) begin
                err_sum += real'(int'(ex) - int'(p3)) / real'(ex);
                nz++;
            end
        end
        @(negedge clk) in_valid = 1'b0;
        $display("[TB] mean relative error over %0d nonzero products: %f", nz, err_sum / nz);
    endtask

    task automatic test_hold();
        apply_and_check("hold_load", 4'd7, 4'd7, expected_default(4'd7, 4'd7));
        A = 4'd2; B = 4'd9;
        repeat (3) begin
            @(posedge clk) #1;
            tests_run++;
            if (p3 !== expected_default(4'd7, 4'd7) || ov3 !== 1'b0) begin
                tests_failed++;
                $display("FAIL hold: P=%0d out_valid=%b expected %0d/0",
                         p3, ov3, expected_default(4'd7, 4'd7));
            end
        end
    endtask

    task automatic test_midstream_reset();
        @(negedge clk);
        A = 4'd5; B = 4'd5; in_valid = 1'b1;
        @(posedge clk) #1;
        tests_run++;
        if (p3 !== expected_default(4'd5, 4'd5) || ov3 !== 1'b1) begin
            tests_failed++;
            $display("FAIL mid_pre: P=%0d out_valid=%b expected %0d/1",
                     p3, ov3, expected_default(4'd5, 4'd5));
        end
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if (p3 !== 8'd0 || ov3 !== 1'b0 || p0 !== 8'd0) begin
            tests_failed++;
            $display("FAIL mid_async_reset: P=%0d out_valid=%b P0=%0d expected 0/0/0",
                     p3, ov3, p0);
        end
        @(negedge clk);
        A = 4'd15; B = 4'd15;
        @(posedge clk) #1;
        tests_run++;
        if (p3 !== 8'd0 || ov3 !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_reset_held: P=%0d out_valid=%b expected 0/0", p3, ov3);
        end
        @(negedge clk);
        rst_n = 1'b1; in_valid = 1'b0;
        @(posedge clk) #1;
        tests_run++;
        if (p3 !== 8'd0 || ov3 !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_discard: P=%0d out_valid=%b expected 0/0", p3, ov3);
        end
        apply_and_check("first_after_reset", 4'd15, 4'd15, expected_default(4'd15, 4'd15));
        tests_run++;
        if (p0 !== 8'd225) begin
            tests_failed++;
            $display("FAIL cols0_15x15: P=%0d expected 225", p0);
        end
    endtask

    initial begin
        test_reset();
        test_approx_pairs();
        test_exact_cases();
        test_back_to_back_sweep();
        test_hold();
        test_midstream_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
